// File: rtl/ram_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ram_arb_pkg
//  Brief    : Shared constants and types for the two-port RAM arbiter.
//  Revision : 1.0
// ============================================================================
package ram_arb_pkg;

    localparam int AW   = 7;
    localparam int DW   = 16;
    localparam int NREQ = 2;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } req_t;

    typedef struct packed {
        logic rd;
        logic port;
    } pipe_t;

    // Index of a one-hot two-bit grant vector.
    function automatic logic grant_idx(input logic [NREQ-1:0] g);
        return g[1];
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arb2
//  Brief    : Two-way arbiter, round-robin by default; strict port-0 priority
//             when RAM_ARB_FIXED_PRIO_EN is defined.
//  Revision : 1.0
// ============================================================================
module rr_arb2
    import ram_arb_pkg::*;
(
    input  logic            CLK,
    input  logic            RSTN,
    input  logic [NREQ-1:0] valid,
    input  logic            accept,
    output logic [NREQ-1:0] grant
);

`ifdef RAM_ARB_FIXED_PRIO_EN

    logic w_unused;
    assign w_unused = CLK ^ accept;

    always_comb begin
        grant = '0;
        if (RSTN) begin
            if (valid[0])
                grant = 2'b01;
            else if (valid[1])
                grant = 2'b10;
        end
    end

`else

    // High when port 1 holds the most recent grant; reset prefers port 0.
    logic r_last;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN)
            r_last <= 1'b1;
        else if (accept)
            r_last <= grant[1];
    end

    always_comb begin
        grant = '0;
        if (RSTN) begin
            case (valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = r_last ? 2'b01 : 2'b10;
                default: grant = '0;
            endcase
        end
    end

`endif

endmodule
`default_nettype wire

// File: rtl/ram_arb_2p.sv
`default_nettype none
// ============================================================================
//  Module   : ram_arb_2p
//  Brief    : Two-requester arbiter/sequencer for the ram_128x16A macro with
//             registered macro pins and fixed two-cycle read latency.
//             Build option: RAM_ARB_FIXED_PRIO_EN (strict port-0 priority).
//  Revision : 1.0
// ============================================================================
module ram_arb_2p #(
    parameter int AW = 7,
    parameter int DW = 16
) (
    input  logic            CLK,
    input  logic            RSTN,
    input  logic [1:0]      req_valid,
    output logic [1:0]      req_ready,
    input  logic [1:0]      req_we,
    input  logic [2*AW-1:0] req_addr,
    input  logic [2*DW-1:0] req_wdata,
    output logic [1:0]      rsp_valid,
    output logic [DW-1:0]   rsp_rdata,
    output logic [AW-1:0]   ram_a,
    output logic [DW-1:0]   ram_d,
    output logic            ram_wen,
    output logic            ram_oen,
    input  logic [DW-1:0]   ram_q
);
    import ram_arb_pkg::*;

    logic [NREQ-1:0] w_grant;
    logic            w_acc;
    logic            w_idx;
    req_t            w_req [NREQ];
    req_t            w_sel;

    logic [AW-1:0]   r_ram_a;
    logic [DW-1:0]   r_ram_d;
    logic            r_ram_wen;
    pipe_t           r_s1;
    pipe_t           r_s2;
    logic [1:0]      r_rsp_valid;
    logic [DW-1:0]   r_rsp_rdata;

    rr_arb2 u_arb (
        .CLK    (CLK),
        .RSTN   (RSTN),
        .valid  (req_valid),
        .accept (w_acc),
        .grant  (w_grant)
    );

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
            assign w_req[gi].we    = req_we[gi];
            assign w_req[gi].addr  = req_addr[gi*AW +: AW];
            assign w_req[gi].wdata = req_wdata[gi*DW +: DW];
        end
    endgenerate

    assign w_acc = |w_grant;
    assign w_idx = grant_idx(w_grant);
    assign w_sel = w_req[w_idx];

    // S1 drives the macro pins; S2 tracks the read through the macro's Q cycle.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_ram_a     <= '0;
            r_ram_d     <= '0;
            r_ram_wen   <= 1'b0;
            r_s1        <= '0;
            r_s2        <= '0;
            r_rsp_valid <= '0;
            r_rsp_rdata <= '0;
        end else begin
            if (w_acc) begin
                r_ram_a <= w_sel.addr;
                r_ram_d <= w_sel.wdata;
            end
            r_ram_wen   <= w_acc & w_sel.we;
            r_s1.rd     <= w_acc & ~w_sel.we;
            r_s1.port   <= w_idx;
            r_s2        <= r_s1;
            r_rsp_valid <= '0;
            if (r_s2.rd) begin
                r_rsp_rdata              <= ram_q;
                r_rsp_valid[r_s2.port]   <= 1'b1;
            end
        end
    end

    assign req_ready = w_grant;
    assign ram_a     = r_ram_a;
    assign ram_d     = r_ram_d;
    assign ram_wen   = r_ram_wen;
    assign ram_oen   = r_s2.rd;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;

endmodule
`default_nettype wire
